// File: rtl/coin_pkg.sv
// Shared coin codes and acceptor state encoding; the vending FSM imports the
// same coin codes so both ends of the coin bus agree.
package coin_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BOTH = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    RELEASE,
    FAULT
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, cleared to zero on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronise, debounce and qualify sensor levels into
// one-cycle coin/reject pulses for the vending FSM, with a sticky stuck flag.
//
// state   | meaning
// IDLE    | both sensors released, waiting for a non-zero pattern
// QUAL    | counting consecutive samples equal to the captured pattern
// RELEASE | pulse issued; waiting for a debounced release or a stuck sensor
// FAULT   | sensor stuck; sensors ignored until reset
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STUCK_CYCLES    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sense5,
  input  logic       sense10,
  input  logic       inhibit,
  output logic [1:0] coin,
  output logic       reject,
  output logic       fault
);

  localparam int CW = $clog2(STUCK_CYCLES + 1);
  localparam logic [CW-1:0] DEB_MAX   = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] STUCK_MAX = CW'(STUCK_CYCLES);

  logic [1:0]    p;
  state_t        state, state_nx;
  logic [1:0]    kind, kind_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CW-1:0] cnt_inc, run;
  logic          rel_hi, rel_hi_nx;
  logic [1:0]    coin_nx;
  logic          reject_nx, fault_nx;

  sync_2ff #(.WIDTH(2)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({sense10, sense5}),
    .q     (p)
  );

  assign cnt_inc = cnt + CW'(1);
  // Shared counter: keep counting while the level matches the last one, else restart at 1.
  assign run = ((p != COIN_NONE) == rel_hi) ? cnt_inc : CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      kind   <= COIN_NONE;
      cnt    <= '0;
      rel_hi <= 1'b1;
      coin   <= COIN_NONE;
      reject <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= state_nx;
      kind   <= kind_nx;
      cnt    <= cnt_nx;
      rel_hi <= rel_hi_nx;
      coin   <= coin_nx;
      reject <= reject_nx;
      fault  <= fault_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    kind_nx   = kind;
    cnt_nx    = cnt;
    rel_hi_nx = rel_hi;
    coin_nx   = COIN_NONE;
    reject_nx = 1'b0;
    fault_nx  = fault;
    case (state)
      IDLE: begin
        if (p != COIN_NONE) begin
          kind_nx  = p;
          cnt_nx   = CW'(1);
          state_nx = QUAL;
        end
      end
      QUAL: begin
        if (p == kind) begin
          if (cnt_inc == DEB_MAX) begin
            if (inhibit || kind == COIN_BOTH) reject_nx = 1'b1;
            else                              coin_nx   = kind;
            state_nx  = RELEASE;
            cnt_nx    = '0;
            rel_hi_nx = 1'b1;
          end else begin
            cnt_nx = cnt_inc;
          end
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      RELEASE: begin
        if (p == COIN_NONE && run == DEB_MAX) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (p != COIN_NONE && run == STUCK_MAX) begin
          state_nx = FAULT;
          fault_nx = 1'b1;
          cnt_nx   = '0;
        end else begin
          cnt_nx    = run;
          rel_hi_nx = (p != COIN_NONE);
        end
      end
      FAULT: begin
        fault_nx = 1'b1;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: per-edge expected pulses come from a
// press-level model (start edge, length, inhibit) rather than the FSM itself.
module tb_coin_acceptor;
  import coin_pkg::*;

  localparam int D = 4;
  localparam int S = 64;
  localparam int NEVER = 1 << 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sense5 = 1'b0;
  logic       sense10 = 1'b0;
  logic       inhibit = 1'b0;
  logic [1:0] coin;
  logic       reject;
  logic       fault;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;
  int fault_edge = NEVER;
  int credit = 0;
  int dispenses = 0;
  logic [1:0] exp_coin [int];
  bit         exp_rej  [int];

  always #5 clk = ~clk;

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .STUCK_CYCLES(S)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sense5  (sense5),
    .sense10 (sense10),
    .inhibit (inhibit),
    .coin    (coin),
    .reject  (reject),
    .fault   (fault)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit expired at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  // Drive one sample, clock it, then compare outputs against the model for that edge.
  task automatic tick(input logic [1:0] pat, input logic inh);
    logic [1:0] ec;
    logic       er, ef;
    {sense10, sense5} = pat;
    inhibit = inh;
    @(posedge clk);
    edge_n++;
    #1;
    ec = exp_coin.exists(edge_n) ? exp_coin[edge_n] : COIN_NONE;
    er = exp_rej.exists(edge_n) ? exp_rej[edge_n] : 1'b0;
    ef = (edge_n >= fault_edge);
    n_cmp++;
    if (coin !== ec) begin
      n_err++;
      $display("FAIL coin edge %0d: got %b want %b", edge_n, coin, ec);
    end
    n_cmp++;
    if (reject !== er) begin
      n_err++;
      $display("FAIL reject edge %0d: got %b want %b", edge_n, reject, er);
    end
    n_cmp++;
    if (fault !== ef) begin
      n_err++;
      $display("FAIL fault edge %0d: got %b want %b", edge_n, fault, ef);
    end
    if (coin == COIN_5)  credit += 5;
    if (coin == COIN_10) credit += 10;
    if (credit >= 20) begin
      credit -= 20;
      dispenses++;
    end
  endtask

  // One physical insertion: pattern held for len samples then released for gap.
  task automatic press(input logic [1:0] kind, input int len, input int gap,
                       input logic inh_q, input logic inh_o);
    int e0, eq;
    e0 = edge_n + 1;
    eq = e0 + D + 1;
    if (len >= D && e0 < fault_edge) begin
      if (inh_q || kind == 2'b11) exp_rej[eq] = 1'b1;
      else                        exp_coin[eq] = kind;
      if (len - D >= S) fault_edge = eq + S;
    end
    for (int i = 0; i < len + gap; i++)
      tick((i < len) ? kind : 2'b00, (i == D + 1) ? inh_q : inh_o);
  endtask

  task automatic check_quiet(input string name);
    n_cmp++;
    if (coin !== 2'b00 || reject !== 1'b0 || fault !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got coin=%b reject=%b fault=%b want 00/0/0", name, coin, reject, fault);
    end
  endtask

  task automatic apply_reset(input int hold);
    rst_n = 1'b0;
    fault_edge = NEVER;
    exp_coin.delete();
    exp_rej.delete();
    #1;
    check_quiet("reset_async");
    repeat (hold) tick(2'b00, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick(2'b00, 1'b0);
  endtask

  task automatic test_reset();
    #3;
    check_quiet("reset_initial");
    apply_reset(3);
    check_quiet("reset_released");
  endtask

  task automatic test_clean5();
    press(2'b01, 10, 8, 1'b0, 1'b0);
  endtask

  task automatic test_glitch();
    press(2'b10, 3, 1, 1'b0, 1'b0);
    repeat (4) press(2'b10, 1, 1, 1'b0, 1'b0);
    repeat (6) tick(2'b00, 1'b0);
  endtask

  task automatic test_both();
    press(2'b11, 8, 6, 1'b0, 1'b0);
    press(2'b10, 6, 8, 1'b0, 1'b0);
  endtask

  task automatic test_inhibit();
    press(2'b01, 8, 8, 1'b1, 1'b1);
    press(2'b01, 8, 8, 1'b0, 1'b1);
    press(2'b10, 5, 8, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [1:0] k;
      k = 2'($urandom_range(1, 3));
      press(k, int'($urandom_range(1, 12)), int'($urandom_range(D + 2, D + 8)),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_chain();
    apply_reset(2);
    credit = 0;
    dispenses = 0;
    press(2'b01, 6, 8, 1'b0, 1'b0);
    press(2'b01, 7, 8, 1'b0, 1'b0);
    press(2'b10, 6, 8, 1'b0, 1'b0);
    n_cmp++;
    if (dispenses !== 1 || credit !== 0) begin
      n_err++;
      $display("FAIL chain_dispense: got dispenses=%0d credit=%0d want 1/0", dispenses, credit);
    end
  endtask

  task automatic test_stuck();
    press(2'b01, 100, 20, 1'b0, 1'b0);
    press(2'b10, 8, 8, 1'b0, 1'b0);
    apply_reset(3);
    check_quiet("stuck_cleared");
    press(2'b01, 6, 8, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    repeat (4) tick(2'b01, 1'b0);
    rst_n = 1'b0;
    fault_edge = NEVER;
    #1;
    check_quiet("mid_reset_async");
    repeat (4) tick(2'b01, 1'b0);
    {sense10, sense5} = 2'b00;
    rst_n = 1'b1;
    repeat (10) tick(2'b00, 1'b0);
    press(2'b01, 6, 8, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_clean5();
    test_glitch();
    test_both();
    test_inhibit();
    test_random();
    test_chain();
    test_stuck();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
